// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared period counter (sawtooth or triangle) with shadowed mode/limit.
// commit is high on the wrap edge and on every disabled cycle.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BIT_WIDTH-1:0] max_value,
    input  logic                 center_mode,
    output logic [BIT_WIDTH-1:0] cnt,
    output logic                 commit,
    output logic                 period_start
);

    dir_e                 dir;
    mode_e                mode_act;
    logic [BIT_WIDTH-1:0] max_act;
    logic                 wrap;

    always_comb begin
        if (mode_act == PWM_CENTER) begin
            wrap = (cnt == '0) && (dir == DIR_DOWN);
        end else begin
            wrap = (cnt == max_act);
        end
    end

    assign commit       = ~enable | wrap;
    // Gated by rst so the output reads low while reset is held.
    assign period_start = enable & ~rst & (cnt == '0) & (dir == DIR_UP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            dir      <= DIR_UP;
            max_act  <= '0;
            mode_act <= PWM_EDGE;
        end else begin
            if (commit) begin
                max_act  <= max_value;
                mode_act <= mode_e'(center_mode);
            end
            if (!enable) begin
                cnt <= '0;
                dir <= DIR_UP;
            end else if (mode_act == PWM_EDGE) begin
                dir <= DIR_UP;
                cnt <= wrap ? '0 : cnt + 1'b1;
            end else if (dir == DIR_UP) begin
                // The counter holds for one cycle at each turning point.
                if (cnt == max_act) dir <= DIR_DOWN;
                else                cnt <= cnt + 1'b1;
            end else begin
                if (cnt == '0) dir <= DIR_UP;
                else           cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: double-buffered duty banks compared against a shared timebase.
// pwm_out is registered and lags count by one cycle.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter  int BIT_WIDTH = 8,
    parameter  int CHANNELS  = 4,
    localparam int CH_W      = ch_w(CHANNELS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BIT_WIDTH-1:0] max_value,
    input  logic                 center_mode,
    input  logic                 duty_wr_en,
    input  logic [CH_W-1:0]      duty_wr_ch,
    input  logic [BIT_WIDTH:0]   duty_wr_data,
    output logic [CHANNELS-1:0]  pwm_out,
    output logic                 period_start,
    output logic [BIT_WIDTH-1:0] count
);

    logic [BIT_WIDTH-1:0] cnt;
    logic                 commit;

    pwm_timebase #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .max_value   (max_value),
        .center_mode (center_mode),
        .cnt         (cnt),
        .commit      (commit),
        .period_start(period_start)
    );

    assign count = cnt;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [BIT_WIDTH:0] duty_pend;
        logic [BIT_WIDTH:0] duty_act;
        logic               pwm_q;

        // A write on a commit edge lands in duty_pend only; duty_act takes the old value.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                duty_pend <= '0;
                duty_act  <= '0;
                pwm_q     <= 1'b0;
            end else begin
                if (commit) duty_act <= duty_pend;
                if (duty_wr_en && (duty_wr_ch == CH_W'(i))) duty_pend <= duty_wr_data;
                pwm_q <= enable & ({1'b0, cnt} < duty_act);
            end
        end

        assign pwm_out[i] = pwm_q;
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Randomized scoreboard bench for pwm_multi_channel against a phase-based reference model.
module tb_pwm_multi_channel;

    localparam int BW = 3;
    localparam int CH = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [BW-1:0] max_value;
    logic          center_mode;
    logic          duty_wr_en;
    logic [CW-1:0] duty_wr_ch;
    logic [BW:0]   duty_wr_data;
    logic [CH-1:0] pwm_out;
    logic          period_start;
    logic [BW-1:0] count;

    always #5 clk = ~clk;

    pwm_multi_channel #(.BIT_WIDTH(BW), .CHANNELS(CH)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .max_value   (max_value),
        .center_mode (center_mode),
        .duty_wr_en  (duty_wr_en),
        .duty_wr_ch  (duty_wr_ch),
        .duty_wr_data(duty_wr_data),
        .pwm_out     (pwm_out),
        .period_start(period_start),
        .count       (count)
    );

    typedef struct {
        int pwm;
        int ps;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: position within the period, not counter/direction state.
    int m_p, m_max, m_mode, m_pwm;
    int d_act[CH];
    int d_pend[CH];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int p, input int m, input int md);
        if (md == 0) return p;
        return (p <= m) ? p : 2 * m + 1 - p;
    endfunction

    function automatic int cur_cnt();
        return cnt_of(m_p, m_max, m_mode);
    endfunction

    task automatic model_reset();
        m_p = 0; m_max = 0; m_mode = 0; m_pwm = 0;
        for (int i = 0; i < CH; i++) begin
            d_act[i]  = 0;
            d_pend[i] = 0;
        end
    endtask

    task automatic model_edge();
        int c, per, en, cm;
        bit wrap;
        en   = int'(enable);
        c    = cur_cnt();
        per  = (m_mode != 0) ? 2 * (m_max + 1) : m_max + 1;
        wrap = (en != 0) && (m_p == per - 1);
        m_pwm = 0;
        for (int i = 0; i < CH; i++)
            if (en != 0 && c < d_act[i]) m_pwm |= (1 << i);
        if (en == 0 || wrap) begin
            for (int i = 0; i < CH; i++) d_act[i] = d_pend[i];
            m_max  = int'(max_value);
            cm     = int'(center_mode);
            m_mode = cm;
        end
        if (duty_wr_en && int'(duty_wr_ch) < CH) d_pend[duty_wr_ch] = int'(duty_wr_data);
        m_p = (en == 0 || wrap) ? 0 : m_p + 1;
    endtask

    task automatic step(input logic en, input logic [BW-1:0] mx, input logic cm,
                        input logic we, input logic [CW-1:0] ch, input logic [BW:0] dat);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        enable = en; max_value = mx; center_mode = cm;
        duty_wr_en = we; duty_wr_ch = ch; duty_wr_data = dat;
        e.pwm = m_pwm;
        e.ps  = (en && m_p == 0) ? 1 : 0;
        e.cnt = cur_cnt();
        q.push_back(e);
    endtask

    task automatic idle(input int n, input logic en, input logic [BW-1:0] mx, input logic cm);
        for (int i = 0; i < n; i++) step(en, mx, cm, 1'b0, '0, '0);
    endtask

    task automatic run_until_cnt(input int target, input logic [BW-1:0] mx, input logic cm);
        int guard = 0;
        while (cur_cnt() != target && guard < 40) begin
            step(1'b1, mx, cm, 1'b0, '0, '0);
            guard++;
        end
        chk("reach_count", cur_cnt(), target);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_pwm"}, int'(pwm_out), 0);
        chk({tag, "_period_start"}, int'(period_start), 0);
        chk({tag, "_count"}, int'(count), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pwm_out", int'(pwm_out), e.pwm);
            chk("period_start", int'(period_start), e.ps);
            chk("count", int'(count), e.cnt);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [BW-1:0] rmx;
        logic          rcm;
        rst = 1'b1; enable = 1'b1; max_value = '0; center_mode = 1'b0;
        duty_wr_en = 1'b0; duty_wr_ch = '0; duty_wr_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check_zero_outputs("reset");
        @(negedge clk);
        #1;
        rst = 1'b0; enable = 1'b0;

        // Edge mode M=7: ch0=3, ch1=0, ch2=8, ch3 write is out of range.
        step(1'b0, 3'd7, 1'b0, 1'b1, 2'd0, 4'd3);
        step(1'b0, 3'd7, 1'b0, 1'b1, 2'd1, 4'd0);
        step(1'b0, 3'd7, 1'b0, 1'b1, 2'd2, 4'd8);
        step(1'b0, 3'd7, 1'b0, 1'b1, 2'd3, 4'd5);
        idle(24, 1'b1, 3'd7, 1'b0);

        // Mid-period write (sampled at cnt=2) and write on the wrap edge (cnt=7).
        run_until_cnt(1, 3'd7, 1'b0);
        step(1'b1, 3'd7, 1'b0, 1'b1, 2'd0, 4'd6);
        idle(20, 1'b1, 3'd7, 1'b0);
        run_until_cnt(6, 3'd7, 1'b0);
        step(1'b1, 3'd7, 1'b0, 1'b1, 2'd1, 4'd4);
        idle(24, 1'b1, 3'd7, 1'b0);

        // Center mode M=3, ch0=2.
        step(1'b0, 3'd3, 1'b1, 1'b1, 2'd0, 4'd2);
        step(1'b0, 3'd3, 1'b1, 1'b0, 2'd0, 4'd0);
        idle(24, 1'b1, 3'd3, 1'b1);

        // Asynchronous reset while cnt=5 in edge mode.
        step(1'b0, 3'd7, 1'b0, 1'b0, 2'd0, 4'd0);
        run_until_cnt(5, 3'd7, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        idle(12, 1'b1, 3'd7, 1'b0);

        // Enable dropped mid-period; new D and M written while disabled.
        step(1'b1, 3'd7, 1'b0, 1'b1, 2'd0, 4'd5);
        idle(10, 1'b1, 3'd7, 1'b0);
        run_until_cnt(3, 3'd7, 1'b0);
        step(1'b0, 3'd4, 1'b0, 1'b1, 2'd0, 4'd1);
        step(1'b0, 3'd4, 1'b0, 1'b1, 2'd2, 4'd3);
        idle(3, 1'b0, 3'd4, 1'b0);
        idle(20, 1'b1, 3'd4, 1'b0);

        // Randomized traffic, including M=0 and rare enable drops.
        rmx = 3'd5; rcm = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) rmx = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) rcm = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 15) != 0), rmx, rcm,
                 1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
